// File: rtl/wr_fifo_drain_ctrl.sv
// wr_fifo_drain_ctrl: drains the store write FIFO onto the shared 64-bit data-memory port
// and arbitrates that port against memory-stage loads. Each FIFO entry becomes one or two
// 8-byte-aligned, byte-enabled write beats; accesses crossing an 8-byte boundary are split.
// Optional feature: define WR_DRAIN_LD_PRIO_EN to let pending loads beat pending stores
// unless the FIFO is full or drain_all is asserted. Default build: stores win when the
// FIFO is non-empty.
module wr_fifo_drain_ctrl #(
  parameter int unsigned DATA_W = 98
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fifo_empty,
  input  logic              i_fifo_full,
  input  logic [DATA_W-1:0] i_fifo_rd_data,
  output logic              o_fifo_rd,
  input  logic              i_drain_all,
  input  logic              i_ld_req,
  input  logic [31:0]       i_ld_addr,
  output logic              o_ld_gnt,
  output logic              o_mem_req,
  output logic              o_mem_wr,
  output logic [31:0]       o_mem_addr,
  output logic [7:0]        o_mem_be,
  output logic [63:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  output logic              o_drained
);

  typedef enum logic [1:0] {StIdle, StStLo, StStHi, StLd} state_e;

  state_e r_state, w_state_d;

  logic        r_mem_req, w_mem_req_d;
  logic        r_mem_wr, w_mem_wr_d;
  logic [31:0] r_mem_addr, w_mem_addr_d;
  logic [7:0]  r_mem_be, w_mem_be_d;
  logic [63:0] r_mem_wdata, w_mem_wdata_d;

  // Head-entry decode
  logic [63:0]  w_st_data;
  logic [31:0]  w_st_addr;
  logic [1:0]   w_st_size;
  logic [2:0]   w_off;
  logic [7:0]   w_nmask8;
  logic [15:0]  w_mask16;
  logic [127:0] w_sh128;
  logic [31:0]  w_base;
  logic         w_split;

  logic w_ack;
  logic w_pick_st;
  logic w_pick_ld;
  logic w_last_st;
  logic w_ld_done;

  assign w_st_data = i_fifo_rd_data[97:34];
  assign w_st_addr = i_fifo_rd_data[33:2];
  assign w_st_size = i_fifo_rd_data[1:0];
  assign w_off     = w_st_addr[2:0];
  assign w_base    = {w_st_addr[31:3], 3'b000};

  // Size code to an unshifted byte mask of n = 1/2/4/8 bytes
  always_comb begin
    w_nmask8 = 8'h01;
    unique case (w_st_size)
      2'b00:   w_nmask8 = 8'h01;
      2'b01:   w_nmask8 = 8'h03;
      2'b10:   w_nmask8 = 8'h0F;
      2'b11:   w_nmask8 = 8'hFF;
      default: w_nmask8 = 8'h01;
    endcase
  end

  // The upper halves of mask/data feed the second beat of a split store
  assign w_mask16 = {8'h00, w_nmask8} << w_off;
  assign w_sh128  = {64'h0, w_st_data} << {w_off, 3'b000};
  assign w_split  = |w_mask16[15:8];

  // An ack only counts while a beat is actually presented
  assign w_ack = i_mem_ack & r_mem_req;

`ifdef WR_DRAIN_LD_PRIO_EN
  assign w_pick_st = ~i_fifo_empty & (i_fifo_full | i_drain_all | ~i_ld_req);
`else
  assign w_pick_st = ~i_fifo_empty;
`endif
  assign w_pick_ld = ~w_pick_st & i_ld_req;

  // Next-state and next memory-beat computation
  always_comb begin
    w_state_d     = r_state;
    w_mem_req_d   = r_mem_req;
    w_mem_wr_d    = r_mem_wr;
    w_mem_addr_d  = r_mem_addr;
    w_mem_be_d    = r_mem_be;
    w_mem_wdata_d = r_mem_wdata;
    w_last_st     = 1'b0;
    w_ld_done     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_st) begin
          w_state_d     = StStLo;
          w_mem_req_d   = 1'b1;
          w_mem_wr_d    = 1'b1;
          w_mem_addr_d  = w_base;
          w_mem_be_d    = w_mask16[7:0];
          w_mem_wdata_d = w_sh128[63:0];
        end else if (w_pick_ld) begin
          w_state_d     = StLd;
          w_mem_req_d   = 1'b1;
          w_mem_wr_d    = 1'b0;
          w_mem_addr_d  = {i_ld_addr[31:3], 3'b000};
          w_mem_be_d    = 8'hFF;
          w_mem_wdata_d = 64'h0;
        end
      end
      StStLo: begin
        if (w_ack) begin
          if (w_split) begin
            // Second beat issues straight away; wraps modulo 2^32
            w_state_d     = StStHi;
            w_mem_addr_d  = w_base + 32'd8;
            w_mem_be_d    = w_mask16[15:8];
            w_mem_wdata_d = w_sh128[127:64];
          end else begin
            w_state_d   = StIdle;
            w_mem_req_d = 1'b0;
            w_last_st   = 1'b1;
          end
        end
      end
      StStHi: begin
        if (w_ack) begin
          w_state_d   = StIdle;
          w_mem_req_d = 1'b0;
          w_last_st   = 1'b1;
        end
      end
      StLd: begin
        if (w_ack) begin
          w_state_d   = StIdle;
          w_mem_req_d = 1'b0;
          w_ld_done   = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and registered memory-port outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 8'h0;
      r_mem_wdata <= 64'h0;
    end else begin
      r_state     <= w_state_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_wr    <= w_mem_wr_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_be    <= w_mem_be_d;
      r_mem_wdata <= w_mem_wdata_d;
    end
  end

  // A pop or grant during reset would act on state that is being discarded
  assign o_fifo_rd   = w_last_st & i_rst_n & ~i_fifo_empty;
  assign o_ld_gnt    = w_ld_done & i_rst_n;
  assign o_mem_req   = r_mem_req;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_drained   = (r_state == StIdle) & i_fifo_empty;

endmodule

// File: tb/tb_wr_fifo_drain_ctrl.sv
// Self-checking bench for wr_fifo_drain_ctrl. A queue-based FIFO model feeds the DUT and a
// transaction-level reference expands each decision into a list of expected memory beats.
module tb_wr_fifo_drain_ctrl;

  localparam int unsigned DATA_W = 98;
  localparam int unsigned DEPTH  = 4;
  localparam byte EV_ST = 8'h53;
  localparam byte EV_LD = 8'h4C;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd;
  logic              drain_all;
  logic              ld_req;
  logic [31:0]       ld_addr;
  logic              ld_gnt;
  logic              mem_req;
  logic              mem_wr;
  logic [31:0]       mem_addr;
  logic [7:0]        mem_be;
  logic [63:0]       mem_wdata;
  logic              mem_ack;
  logic              drained;

  wr_fifo_drain_ctrl #(.DATA_W(DATA_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_full   (fifo_full),
    .i_fifo_rd_data(fifo_rd_data),
    .o_fifo_rd     (fifo_rd),
    .i_drain_all   (drain_all),
    .i_ld_req      (ld_req),
    .i_ld_addr     (ld_addr),
    .o_ld_gnt      (ld_gnt),
    .o_mem_req     (mem_req),
    .o_mem_wr      (mem_wr),
    .o_mem_addr    (mem_addr),
    .o_mem_be      (mem_be),
    .o_mem_wdata   (mem_wdata),
    .i_mem_ack     (mem_ack),
    .o_drained     (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;

  logic [DATA_W-1:0] q_fifo[$];
  beat_t             q_beats[$];
  byte               ev_log[$];
  bit                cur_store;
  bit                full_ovr;

  // Outputs captured at the negedge of the most recent cycle
  logic        obs_req, obs_wr, obs_rd, obs_gnt, obs_drn;
  logic [31:0] obs_addr;
  logic [7:0]  obs_be;
  logic [63:0] obs_wdata;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_entry(input logic [63:0] d, input logic [31:0] a,
                                                 input logic [1:0] s);
    return {d, a, s};
  endfunction

  // Expand a store entry into its beats straight from the byte-lane arithmetic
  function automatic void add_store_beats(input logic [DATA_W-1:0] e);
    logic [63:0]  d;
    logic [31:0]  a;
    int           n;
    int           off;
    int           mask_i;
    logic [15:0]  mask;
    logic [127:0] sh;
    beat_t        b;
    d      = e[97:34];
    a      = e[33:2];
    n      = 1 << e[1:0];
    off    = int'(a[2:0]);
    mask_i = ((1 << n) - 1) << off;
    mask   = mask_i[15:0];
    sh     = {64'h0, d} << (8 * off);
    b.wr   = 1'b1;
    b.addr = a & ~32'h7;
    b.be   = mask[7:0];
    b.wdata = sh[63:0];
    q_beats.push_back(b);
    if (mask[15:8] != 8'h0) begin
      b.addr  = (a & ~32'h7) + 32'd8;
      b.be    = mask[15:8];
      b.wdata = sh[127:64];
      q_beats.push_back(b);
    end
  endfunction

  function automatic bit model_pick_store();
`ifdef WR_DRAIN_LD_PRIO_EN
    if (fifo_empty) return 1'b0;
    if (fifo_full || drain_all) return 1'b1;
    return !ld_req;
`else
    return !fifo_empty;
`endif
  endfunction

  // One clock: present FIFO head, compare at negedge, update model after posedge
  task automatic cycle();
    beat_t             b;
    logic [DATA_W-1:0] dummy;
    logic              e_req, e_rd, e_gnt, e_drn;
    bit                pop, gnt;
    fifo_empty   = (q_fifo.size() == 0);
    fifo_full    = (q_fifo.size() >= DEPTH) || full_ovr;
    fifo_rd_data = fifo_empty ? '0 : q_fifo[0];
    @(negedge clk);
    obs_req = mem_req; obs_wr = mem_wr; obs_addr = mem_addr; obs_be = mem_be;
    obs_wdata = mem_wdata; obs_rd = fifo_rd; obs_gnt = ld_gnt; obs_drn = drained;
    pop = 1'b0;
    gnt = 1'b0;
    if (rst_n) begin
      if (fifo_rd) ev_log.push_back(EV_ST);
      if (ld_gnt)  ev_log.push_back(EV_LD);
      e_rd  = 1'b0;
      e_gnt = 1'b0;
      if (q_beats.size() == 0) begin
        e_req = 1'b0;
        e_drn = fifo_empty;
        if (model_pick_store()) begin
          cur_store = 1'b1;
          add_store_beats(q_fifo[0]);
        end else if (ld_req) begin
          cur_store = 1'b0;
          b.wr = 1'b0; b.addr = ld_addr & ~32'h7; b.be = 8'hFF; b.wdata = '0;
          q_beats.push_back(b);
        end
      end else begin
        b     = q_beats[0];
        e_req = 1'b1;
        e_drn = 1'b0;
        check_eq("mem_wr", mem_wr, b.wr);
        check_eq("mem_addr", mem_addr, b.addr);
        check_eq("mem_be", mem_be, b.be);
        if (b.wr) check_eq("mem_wdata", mem_wdata, b.wdata);
        if (mem_ack) begin
          b = q_beats.pop_front();
          if (q_beats.size() == 0) begin
            if (cur_store) e_rd = 1'b1;
            else e_gnt = 1'b1;
          end
        end
      end
      check_eq("mem_req", mem_req, e_req);
      check_eq("fifo_rd", fifo_rd, e_rd);
      check_eq("ld_gnt", ld_gnt, e_gnt);
      check_eq("drained", drained, e_drn);
      pop = e_rd;
      gnt = e_gnt;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q_fifo.delete();
      q_beats.delete();
      ld_req = 1'b0;
    end else begin
      if (pop && q_fifo.size() != 0) dummy = q_fifo.pop_front();
      if (gnt) ld_req = 1'b0;
    end
  endtask

  function automatic logic [23:0] first3();
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < ev_log.size()) v[23-8*i -: 8] = ev_log[i];
    end
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; mem_ack = 1'b0; ld_req = 1'b0; ld_addr = '0; drain_all = 1'b0;
    full_ovr = 1'b0; cur_store = 1'b0;
    cycle();
    cycle();
    check_eq("rst_mem_req", obs_req, 1'b0);
    check_eq("rst_mem_wr", obs_wr, 1'b0);
    check_eq("rst_mem_addr", obs_addr, 32'h0);
    check_eq("rst_mem_be", obs_be, 8'h0);
    check_eq("rst_mem_wdata", obs_wdata, 64'h0);
    check_eq("rst_fifo_rd", obs_rd, 1'b0);
    check_eq("rst_ld_gnt", obs_gnt, 1'b0);
    check_eq("rst_drained", obs_drn, 1'b1);
    rst_n = 1'b1;
    cycle();

    // Aligned 4-byte store
    mem_ack = 1'b1;
    q_fifo.push_back(mk_entry(64'h11223344, 32'h1000, 2'b10));
    cycle();
    check_eq("al_dec_req", obs_req, 1'b0);
    cycle();
    check_eq("al_addr", obs_addr, 32'h1000);
    check_eq("al_be", obs_be, 8'h0F);
    check_eq("al_wdata", obs_wdata, 64'h11223344);
    check_eq("al_fifo_rd", obs_rd, 1'b1);
    cycle();
    check_eq("al_drained", obs_drn, 1'b1);

    // Split 4-byte store crossing into the next doubleword
    ev_log.delete();
    q_fifo.push_back(mk_entry(64'hAABBCCDD, 32'h1006, 2'b10));
    cycle();
    cycle();
    check_eq("sp1_addr", obs_addr, 32'h1000);
    check_eq("sp1_be", obs_be, 8'hC0);
    check_eq("sp1_wdata_hi", obs_wdata[63:48], 16'hCCDD);
    check_eq("sp1_fifo_rd", obs_rd, 1'b0);
    cycle();
    check_eq("sp2_addr", obs_addr, 32'h1008);
    check_eq("sp2_be", obs_be, 8'h03);
    check_eq("sp2_wdata_lo", obs_wdata[15:0], 16'hAABB);
    check_eq("sp2_fifo_rd", obs_rd, 1'b1);
    cycle();
    check_eq("sp_pop_count", ev_log.size(), 1);

    // 8-byte store wrapping past the top of the address space
    q_fifo.push_back(mk_entry(64'h0123456789ABCDEF, 32'hFFFFFFFC, 2'b11));
    cycle();
    cycle();
    check_eq("wr1_addr", obs_addr, 32'hFFFFFFF8);
    check_eq("wr1_be", obs_be, 8'hF0);
    cycle();
    check_eq("wr2_addr", obs_addr, 32'h00000000);
    check_eq("wr2_be", obs_be, 8'h0F);
    cycle();

    // Arbitration: load request alongside two pending stores
    ev_log.delete();
    q_fifo.push_back(mk_entry(64'h55, 32'h2000, 2'b00));
    q_fifo.push_back(mk_entry(64'h66, 32'h2010, 2'b00));
    ld_req = 1'b1; ld_addr = 32'h3004;
    for (int i = 0; i < 12; i++) cycle();
`ifdef WR_DRAIN_LD_PRIO_EN
    check_eq("arb_order", first3(), {EV_LD, EV_ST, EV_ST});
`else
    check_eq("arb_order", first3(), {EV_ST, EV_ST, EV_LD});
`endif

    // fifo_full forces stores ahead of the load
    ev_log.delete();
    full_ovr = 1'b1;
    q_fifo.push_back(mk_entry(64'h77, 32'h2020, 2'b01));
    q_fifo.push_back(mk_entry(64'h88, 32'h2030, 2'b01));
    ld_req = 1'b1; ld_addr = 32'h4000;
    for (int i = 0; i < 12; i++) cycle();
    check_eq("full_order", first3(), {EV_ST, EV_ST, EV_LD});
    full_ovr = 1'b0;

    // Ack withheld for 5 request cycles
    mem_ack = 1'b0;
    q_fifo.push_back(mk_entry(64'hBEEF, 32'h3008, 2'b01));
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("stall_req", obs_req, 1'b1);
      check_eq("stall_addr", obs_addr, 32'h3008);
      check_eq("stall_be", obs_be, 8'h03);
      check_eq("stall_wdata", obs_wdata, 64'hBEEF);
      check_eq("stall_fifo_rd", obs_rd, 1'b0);
    end
    mem_ack = 1'b1;
    cycle();
    check_eq("stall_done_rd", obs_rd, 1'b1);
    cycle();

    // Reset while the second beat of a split store is outstanding
    ev_log.delete();
    q_fifo.push_back(mk_entry(64'hAABBCCDD, 32'h1006, 2'b10));
    cycle();
    cycle();
    mem_ack = 1'b0;
    rst_n   = 1'b0;
    cycle();
    check_eq("rsthi_in_hi", obs_addr, 32'h1008);
    rst_n = 1'b1;
    cycle();
    check_eq("rsthi_req", obs_req, 1'b0);
    check_eq("rsthi_idle", obs_drn, 1'b1);
    check_eq("rsthi_fifo_rd", obs_rd, 1'b0);
    check_eq("rsthi_pops", ev_log.size(), 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      mem_ack = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 15) == 0) drain_all = ~drain_all;
      if (!ld_req && $urandom_range(0, 5) == 0) begin
        ld_req  = 1'b1;
        ld_addr = $urandom;
      end
      if (q_fifo.size() < DEPTH && $urandom_range(0, 2) == 0)
        q_fifo.push_back(mk_entry({$urandom, $urandom}, $urandom, 2'($urandom_range(0, 3))));
      rst_n = ($urandom_range(0, 599) != 0);
      cycle();
    end

    // Drain everything with zero-wait acks
    rst_n = 1'b1; mem_ack = 1'b1; drain_all = 1'b0;
    for (int i = 0; i < 40; i++) cycle();
    check_eq("final_drained", obs_drn, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
